div_issue_ctrl: RTL and testbench

- EX-stage initiator for the multi-cycle divider unit (DU).
- Accepts DIV/DIVU requests from the pipeline, stalls the pipeline, and launches DU with a one-cycle op pulse on held operands.
- Waits for DU result_ok, then delivers remainder/quotient as a one-shot HI/LO write.
- Also handles divide-by-zero, pipeline flush and a watchdog timeout.

---
 rtl/div_issue_ctrl_pkg.sv | 14 +
 rtl/div_watchdog.sv | 27 ++
 rtl/div_issue_ctrl.sv | 149 ++++++++++++++
 tb/tb_div_issue_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_issue_ctrl_pkg.sv
// Shared constants and FSM encoding for the divider issue controller.
package div_issue_ctrl_pkg;

  localparam logic [7:0]  EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0]  EXE_DIVU_OP = 8'b0001_1011;
  localparam logic [31:0] DZ_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/div_watchdog.sv
// BUSY-cycle counter; flags the MAX_CYCLES-th consecutive enabled cycle.
module div_watchdog #(
  parameter int unsigned MAX_CYCLES = 48
) (
  input  logic clk,
  input  logic sclr,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  localparam int unsigned CntW = $clog2(MAX_CYCLES + 1);

  logic [CntW-1:0] r_cnt;

  // r_cnt holds the number of enabled cycles already completed
  always_ff @(posedge clk) begin
    if (sclr || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CntW'(MAX_CYCLES))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_timeout = i_en && (r_cnt == CntW'(MAX_CYCLES - 1));

endmodule

// File: rtl/div_issue_ctrl.sv
// EX-stage initiator for the multi-cycle divider: stalls, launches the DU, delivers HI/LO once.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = 48,
  parameter int unsigned OP_W       = 8
) (
  input  logic            clk,
  input  logic            sclr,
  input  logic            req_valid,
  input  logic [OP_W-1:0] req_op,
  input  logic [31:0]     req_a,
  input  logic [31:0]     req_b,
  input  logic            flush,
  input  logic            pipe_hold,
  output logic            stall,
  output logic            hilo_we,
  output logic [31:0]     hi_o,
  output logic [31:0]     lo_o,
  output logic            div_zero,
  output logic            timeout_err,
  output logic [OP_W-1:0] du_op,
  output logic [31:0]     du_a,
  output logic [31:0]     du_b,
  output logic            du_clr,
  input  logic            du_ok,
  input  logic [63:0]     du_p
);

  localparam logic [OP_W-1:0] LpDivOp  = OP_W'(EXE_DIV_OP);
  localparam logic [OP_W-1:0] LpDivuOp = OP_W'(EXE_DIVU_OP);

  state_e          r_state, w_state_d;
  logic            r_first;
  logic            r_we_pend;
  logic            r_du_clr;
  logic            r_timeout;
  logic            r_dz;
  logic [OP_W-1:0] r_du_op;
  logic [31:0]     r_du_a, r_du_b, r_hi, r_lo;

  logic w_div_req, w_b_zero, w_ok, w_wd_hit;
  logic w_launch, w_dz, w_capture, w_abort, w_to;

  assign w_div_req = req_valid && ((req_op == LpDivOp) || (req_op == LpDivuOp)) && !flush;
  assign w_b_zero  = (req_b == 32'd0);
  // du_ok may still be asserted from the previous op during the launch cycle
  assign w_ok      = du_ok && !r_first;

  div_watchdog #(
    .MAX_CYCLES(MAX_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .sclr     (sclr),
    .i_clr    (r_state != StBusy),
    .i_en     (r_state == StBusy),
    .o_timeout(w_wd_hit)
  );

  always_comb begin
    w_state_d = r_state;
    w_launch  = 1'b0;
    w_dz      = 1'b0;
    w_capture = 1'b0;
    w_abort   = 1'b0;
    w_to      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_div_req) begin
          if (w_b_zero) begin
            w_dz      = 1'b1;
            w_state_d = StDone;
          end else begin
            w_launch  = 1'b1;
            w_state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (flush) begin
          w_abort   = 1'b1;
          w_state_d = StIdle;
        end else if (w_ok) begin
          w_capture = 1'b1;
          w_state_d = StDone;
        end else if (w_wd_hit) begin
          w_to      = 1'b1;
          w_state_d = StDone;
        end
      end
      StDone: begin
        if (!pipe_hold) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      r_state   <= StIdle;
      r_first   <= 1'b0;
      r_we_pend <= 1'b0;
      r_du_clr  <= 1'b0;
      r_timeout <= 1'b0;
      r_dz      <= 1'b0;
      r_du_op   <= '0;
      r_du_a    <= '0;
      r_du_b    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_state   <= w_state_d;
      r_first   <= w_launch;
      r_du_op   <= w_launch ? req_op : '0;
      r_du_clr  <= w_abort || w_to;
      r_we_pend <= w_dz || w_capture;
      if (w_launch) begin
        r_du_a <= req_a;
        r_du_b <= req_b;
      end
      if (w_dz) begin
        r_hi <= req_a;
        r_lo <= DZ_QUOTIENT;
        r_dz <= 1'b1;
      end else if (w_capture) begin
        r_hi <= du_p[63:32];
        r_lo <= du_p[31:0];
        r_dz <= 1'b0;
      end
      if (w_to) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign stall       = ((r_state == StIdle) && w_div_req) || (r_state == StBusy);
  assign hilo_we     = (r_state == StDone) && r_we_pend && !flush;
  assign hi_o        = r_hi;
  assign lo_o        = r_lo;
  assign div_zero    = r_dz;
  assign timeout_err = r_timeout;
  assign du_op       = r_du_op;
  assign du_a        = r_du_a;
  assign du_b        = r_du_b;
  assign du_clr      = r_du_clr;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl with a behavioural divider model.
module tb_div_issue_ctrl;
  import div_issue_ctrl_pkg::*;

  localparam int MaxC = 48;

  logic        clk = 1'b0;
  logic        sclr, req_valid, flush, pipe_hold;
  logic [7:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        stall, hilo_we, div_zero, timeout_err, du_clr, du_ok;
  logic [31:0] hi_o, lo_o, du_a, du_b;
  logic [7:0]  du_op;
  logic [63:0] du_p;

  int total = 0;
  int bad   = 0;
  int n_we = 0, n_duop = 0, n_clr = 0, cyc = 0, last_op_cyc = 0;
  int du_lat = 36;
  bit du_never = 1'b0;
  logic stale_ok = 1'b0;

  logic        m_run, m_ok;
  int          m_cnt;
  logic [63:0] m_res;

  int we0, op0, clr0, stalls, lat_r, hold_r;
  logic [31:0] a_r, b_r;
  logic [7:0]  op_r;

  div_issue_ctrl #(
    .MAX_CYCLES(MaxC),
    .OP_W      (8)
  ) dut (
    .clk        (clk),
    .sclr       (sclr),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .flush      (flush),
    .pipe_hold  (pipe_hold),
    .stall      (stall),
    .hilo_we    (hilo_we),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .div_zero   (div_zero),
    .timeout_err(timeout_err),
    .du_op      (du_op),
    .du_a       (du_a),
    .du_b       (du_b),
    .du_clr     (du_clr),
    .du_ok      (du_ok),
    .du_p       (du_p)
  );

  always #5 clk = ~clk;

  // Architectural result: {remainder, quotient}; divide by zero gives {a, all-ones}.
  function automatic logic [63:0] ref_div(input logic [7:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op == EXE_DIV_OP) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Divider model: du_ok pulses du_lat cycles after the cycle du_op is seen.
  always @(posedge clk) begin
    if (sclr) begin
      m_run <= 1'b0;
      m_ok  <= 1'b0;
      m_cnt <= 0;
      m_res <= '0;
    end else begin
      m_ok <= 1'b0;
      if (du_op != 8'd0) begin
        m_run <= 1'b1;
        m_cnt <= 1;
        m_res <= ref_div(du_op, du_a, du_b);
      end else if (m_run && !du_never && (m_cnt == du_lat - 1)) begin
        m_ok  <= 1'b1;
        m_run <= 1'b0;
      end else if (m_run) begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  assign du_ok = m_ok || stale_ok;
  assign du_p  = m_res;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (hilo_we === 1'b1) n_we++;
    if (du_op !== 8'd0) begin
      n_duop++;
      last_op_cyc = cyc;
    end
    if (du_clr === 1'b1) n_clr++;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE, follow it to its HI/LO write, hold DONE, then release.
  task automatic run_div(input string nm, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input int hold, input bit stale);
    logic [63:0] exp;
    int w0, o0, st;
    bit done;
    exp = ref_div(op, a, b);
    w0 = n_we; o0 = n_duop; st = 0; done = 1'b0;
    du_lat = lat;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    pipe_hold = (hold > 0);
    stale_ok = stale;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (i == 2) stale_ok = 1'b0;
      if (hilo_we === 1'b1) begin
        done = 1'b1;
        break;
      end
      if (stall === 1'b1) st++;
      @(negedge clk);
    end
    stale_ok = 1'b0;
    chk({nm, "_done"}, 64'(done), 64'(1));
    chk({nm, "_stall_cyc"}, 64'(st), 64'((b == 32'd0) ? 1 : lat + 2));
    if (b != 32'd0) chk({nm, "_latency"}, 64'(cyc - last_op_cyc), 64'(lat + 1));
    chk({nm, "_hilo"}, {hi_o, lo_o}, exp);
    chk({nm, "_dz"}, 64'(div_zero), 64'(b == 32'd0));
    chk({nm, "_done_stall"}, 64'(stall), 64'(0));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      #1;
    end
    pipe_hold = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk({nm, "_we_once"}, 64'(n_we - w0), 64'(1));
    chk({nm, "_launches"}, 64'(n_duop - o0), 64'((b != 32'd0) ? 1 : 0));
    chk({nm, "_held"}, {hi_o, lo_o}, exp);
  endtask

  initial begin
    sclr = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    flush = 1'b0; pipe_hold = 1'b0;
    repeat (3) @(negedge clk);
    sclr = 1'b0;
    #1;
    chk("rst_stall", 64'(stall), 64'(0));
    chk("rst_we", 64'(hilo_we), 64'(0));
    chk("rst_hilo", {hi_o, lo_o}, 64'(0));
    chk("rst_flags", 64'({div_zero, timeout_err, du_clr}), 64'(0));
    chk("rst_du", {du_a, du_b}, 64'(0));
    chk("rst_duop", 64'(du_op), 64'(0));

    // Non-divide op and flushed divide are ignored
    op0 = n_duop;
    req_valid = 1'b1; req_op = 8'h21; req_a = 32'd9; req_b = 32'd3;
    #1 chk("ign_op_stall", 64'(stall), 64'(0));
    repeat (3) @(negedge clk);
    req_op = EXE_DIV_OP; flush = 1'b1;
    #1 chk("ign_flush_stall", 64'(stall), 64'(0));
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    #1 chk("ign_no_launch", 64'(n_duop - op0), 64'(0));

    run_div("div_neg", EXE_DIV_OP, 32'hFFFF_FFFD, 32'd2, 36, 0, 1'b0);
    run_div("divu_big", EXE_DIVU_OP, 32'hFFFF_FFFD, 32'hFFFF_FFF0, 36, 0, 1'b0);
    run_div("div_255", EXE_DIV_OP, 32'd255, 32'd16, 36, 0, 1'b0);
    run_div("div_zero", EXE_DIV_OP, 32'h1234, 32'd0, 36, 0, 1'b0);
    run_div("hold5", EXE_DIVU_OP, 32'd1000, 32'd7, 12, 5, 1'b0);
    run_div("stale_ok", EXE_DIV_OP, 32'hFFFF_FF00, 32'd9, 6, 1, 1'b1);

    // Flush on the first DONE cycle of a divide by zero suppresses the write
    we0 = n_we;
    req_valid = 1'b1; req_op = EXE_DIVU_OP; req_a = 32'h55; req_b = 32'd0;
    @(negedge clk);
    flush = 1'b1;
    #1 chk("dzfl_no_we", 64'(hilo_we), 64'(0));
    chk("dzfl_dz", 64'(div_zero), 64'(1));
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    #1 chk("dzfl_we_cnt", 64'(n_we - we0), 64'(0));

    // Flush in BUSY cycle 10 aborts the DU and never writes
    we0 = n_we; clr0 = n_clr; du_lat = 36;
    req_valid = 1'b1; req_op = EXE_DIVU_OP; req_a = 32'hDEAD_BEEF; req_b = 32'd7;
    @(negedge clk);
    #1 chk("fl_duop", 64'(du_op), 64'(EXE_DIVU_OP));
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1 chk("fl_operands", {du_a, du_b}, {32'hDEAD_BEEF, 32'd7});
    chk("fl_duop_gone", 64'(du_op), 64'(0));
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    #1 chk("fl_clr", 64'(du_clr), 64'(1));
    chk("fl_stall", 64'(stall), 64'(0));
    @(negedge clk);
    #1 chk("fl_clr_pulse", 64'(du_clr), 64'(0));
    repeat (40) @(negedge clk);
    #1 chk("fl_no_we", 64'(n_we - we0), 64'(0));
    chk("fl_clr_cnt", 64'(n_clr - clr0), 64'(1));

    for (int n = 0; n < 16; n++) begin
      op_r = ($urandom_range(0, 1) == 0) ? EXE_DIV_OP : EXE_DIVU_OP;
      a_r = $urandom();
      b_r = $urandom();
      if ($urandom_range(0, 5) == 0) b_r = 32'd0;
      else if ($urandom_range(0, 2) == 0) b_r = 32'($urandom_range(1, 300));
      if (op_r == EXE_DIV_OP && a_r == 32'h8000_0000 && b_r == 32'hFFFF_FFFF) b_r = 32'd3;
      lat_r  = $urandom_range(2, 20);
      hold_r = $urandom_range(0, 3);
      run_div("rnd", op_r, a_r, b_r, lat_r, hold_r, 1'b0);
    end

    // sclr mid-operation abandons the op
    we0 = n_we; du_lat = 20;
    req_valid = 1'b1; req_op = EXE_DIV_OP; req_a = 32'd77; req_b = 32'd5;
    repeat (4) @(negedge clk);
    sclr = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    sclr = 1'b0;
    #1 chk("msr_stall", 64'(stall), 64'(0));
    chk("msr_hilo", {hi_o, lo_o}, 64'(0));
    repeat (30) @(negedge clk);
    #1 chk("msr_no_we", 64'(n_we - we0), 64'(0));

    // DU never answers: watchdog fires after MaxC BUSY cycles
    du_never = 1'b1; we0 = n_we; clr0 = n_clr; stalls = 0;
    req_valid = 1'b1; req_op = EXE_DIVU_OP; req_a = 32'h1357; req_b = 32'd3;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (stall !== 1'b1) break;
      stalls++;
      @(negedge clk);
    end
    chk("to_stall_cyc", 64'(stalls), 64'(MaxC + 1));
    chk("to_busy_cyc", 64'(cyc - last_op_cyc), 64'(MaxC));
    chk("to_clr", 64'(du_clr), 64'(1));
    chk("to_err", 64'(timeout_err), 64'(1));
    chk("to_no_we_now", 64'(hilo_we), 64'(0));
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1 chk("to_sticky", 64'(timeout_err), 64'(1));
    chk("to_no_we", 64'(n_we - we0), 64'(0));
    chk("to_clr_cnt", 64'(n_clr - clr0), 64'(1));
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0; du_never = 1'b0;
    #1 chk("to_cleared", 64'(timeout_err), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
